// File: rtl/i2c_passthru_mstr_det_n.sv
// N-channel I2C passthru master detector: locks the first channel to START as master,
// releases on STOP/timeout/violation/stuck, then enforces a bus-free hold-off.
module i2c_passthru_mstr_det_n #(
    parameter int NUM_CH             = 4,
    parameter int F_REF_T_IDLE       = 511,
    parameter int WIDTH_F_REF_T_IDLE = 9,
    parameter int F_REF_T_BUF        = 38,
    parameter int WIDTH_F_REF_T_BUF  = 6,
    parameter int CW                 = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_f_ref,
    input  logic [NUM_CH-1:0] i_scl,
    input  logic [NUM_CH-1:0] i_sda,
    input  logic [NUM_CH-1:0] i_stuck,
    input  logic              i_violation,
    output logic [NUM_CH-1:0] o_ismst,
    output logic [CW-1:0]     o_mst_idx,
    output logic              o_disconnect,
    output logic              o_start,
    output logic              o_stop,
    output logic              o_idle_timeout,
    output logic              o_collision
);

    localparam logic [WIDTH_F_REF_T_IDLE-1:0] IDLE_MAX = WIDTH_F_REF_T_IDLE'(F_REF_T_IDLE);
    localparam logic [WIDTH_F_REF_T_BUF-1:0]  BUF_MAX  = WIDTH_F_REF_T_BUF'(F_REF_T_BUF);

    typedef enum logic [1:0] {S_IDLE, S_MASTER, S_DISC, S_HOLDOFF} state_t;

    state_t                        state;
    logic [CW-1:0]                 last_mst;
    logic [NUM_CH-1:0]             prev_scl, prev_sda;
    logic [WIDTH_F_REF_T_IDLE-1:0] idle_cnt, idle_nxt;
    logic [WIDTH_F_REF_T_BUF-1:0]  buf_cnt, buf_nxt;

    logic [NUM_CH-1:0] start_v, stop_v;
    logic [CW-1:0]     win, cand;
    logic              found, multi, all_high;

    always_comb begin
        start_v  = prev_sda & ~i_sda & prev_scl & i_scl;
        stop_v   = ~prev_sda & i_sda & prev_scl & i_scl;
        multi    = |(start_v & (start_v - NUM_CH'(1)));
        all_high = (&i_scl) & (&i_sda);

        // Round-robin: first STARTing channel searching upward from last master + 1.
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = CW'((32'(last_mst) + i) % NUM_CH);
            if (!found && start_v[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end

        // Clear wins over a same-cycle tick; both counters saturate.
        if (!(i_scl[o_mst_idx] && i_sda[o_mst_idx]))
            idle_nxt = '0;
        else if (i_f_ref && idle_cnt != IDLE_MAX)
            idle_nxt = idle_cnt + 1'b1;
        else
            idle_nxt = idle_cnt;

        if (!all_high)
            buf_nxt = '0;
        else if (i_f_ref && buf_cnt != BUF_MAX)
            buf_nxt = buf_cnt + 1'b1;
        else
            buf_nxt = buf_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            last_mst       <= CW'(NUM_CH - 1);
            prev_scl       <= '1;
            prev_sda       <= '1;
            idle_cnt       <= '0;
            buf_cnt        <= '0;
            o_ismst        <= '0;
            o_mst_idx      <= '0;
            o_disconnect   <= 1'b0;
            o_start        <= 1'b0;
            o_stop         <= 1'b0;
            o_idle_timeout <= 1'b0;
            o_collision    <= 1'b0;
        end else begin
            prev_scl       <= i_scl;
            prev_sda       <= i_sda;
            o_start        <= 1'b0;
            o_stop         <= 1'b0;
            o_idle_timeout <= 1'b0;
            o_collision    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (|i_stuck) begin
                        state        <= S_DISC;
                        o_disconnect <= 1'b1;
                    end else if (|start_v) begin
                        state       <= S_MASTER;
                        last_mst    <= win;
                        o_mst_idx   <= win;
                        o_ismst     <= NUM_CH'(1) << win;
                        o_start     <= 1'b1;
                        o_collision <= multi;
                        idle_cnt    <= '0;
                    end
                end
                S_MASTER: begin
                    if (i_violation || (|i_stuck)) begin
                        state        <= S_DISC;
                        o_ismst      <= '0;
                        o_disconnect <= 1'b1;
                    end else if (stop_v[o_mst_idx]) begin
                        state   <= S_IDLE;
                        o_ismst <= '0;
                        o_stop  <= 1'b1;
                    end else if (idle_nxt == IDLE_MAX) begin
                        state          <= S_IDLE;
                        o_ismst        <= '0;
                        o_idle_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_nxt;
                        o_start  <= start_v[o_mst_idx];
                    end
                end
                S_DISC: begin
                    if (all_high && !(|i_stuck)) begin
                        state   <= S_HOLDOFF;
                        buf_cnt <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (|i_stuck) begin
                        state <= S_DISC;
                    end else if (buf_nxt == BUF_MAX) begin
                        state        <= S_IDLE;
                        o_disconnect <= 1'b0;
                    end else begin
                        buf_cnt <= buf_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_passthru_mstr_det_n.sv
// Directed self-checking bench for i2c_passthru_mstr_det_n (NUM_CH=4).
module tb_i2c_passthru_mstr_det_n;

    logic       clk = 1'b0;
    logic       rst, f_ref, violation;
    logic [3:0] scl, sda, stuck;
    logic [3:0] ismst;
    logic [1:0] mst_idx;
    logic       disconnect, start, stop, idle_to, collision;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_passthru_mstr_det_n #(
        .NUM_CH(4), .F_REF_T_IDLE(511), .WIDTH_F_REF_T_IDLE(9),
        .F_REF_T_BUF(38), .WIDTH_F_REF_T_BUF(6)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_f_ref(f_ref),
        .i_scl(scl), .i_sda(sda), .i_stuck(stuck), .i_violation(violation),
        .o_ismst(ismst), .o_mst_idx(mst_idx), .o_disconnect(disconnect),
        .o_start(start), .o_stop(stop), .o_idle_timeout(idle_to),
        .o_collision(collision)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_ref = 1'b0; violation = 1'b0;
        scl = 4'hF; sda = 4'hF; stuck = 4'h0;
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++;
        if ({ismst, mst_idx, disconnect, start, stop, idle_to, collision} !== 11'd0) begin
            n_err++;
            $display("FAIL reset: got ismst=%b idx=%0d disc=%b st=%b sp=%b to=%b col=%b, want all 0",
                     ismst, mst_idx, disconnect, start, stop, idle_to, collision);
        end
    endtask

    task automatic test_start_stop();
        sda[2] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, mst_idx, start, collision} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL start_ch2: got ismst=%b idx=%0d st=%b col=%b, want 0100/2/1/0",
                     ismst, mst_idx, start, collision);
        end
        cyc();
        n_cmp++;
        if ({ismst, start} !== {4'b0100, 1'b0}) begin
            n_err++;
            $display("FAIL start_pulse_len: got ismst=%b st=%b, want 0100/0", ismst, start);
        end
        sda[2] = 1'b1; cyc();
        n_cmp++;
        if ({ismst, stop} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL stop_ch2: got ismst=%b sp=%b, want 0000/1", ismst, stop);
        end
    endtask

    task automatic test_collision();
        // last=2 -> ch0 alone wins, making last=0
        sda[0] = 1'b0; cyc();
        sda[0] = 1'b1; cyc();
        sda[0] = 1'b0; sda[3] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, mst_idx, collision} !== {4'b1000, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL collision_a: got ismst=%b idx=%0d col=%b, want 1000/3/1",
                     ismst, mst_idx, collision);
        end
        sda[0] = 1'b1; sda[3] = 1'b1; cyc();
        n_cmp++;
        if ({ismst, stop} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL collision_stop: got ismst=%b sp=%b, want 0000/1", ismst, stop);
        end
        sda[0] = 1'b0; sda[3] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, mst_idx, collision} !== {4'b0001, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL collision_b: got ismst=%b idx=%0d col=%b, want 0001/0/1",
                     ismst, mst_idx, collision);
        end
        sda[0] = 1'b1; sda[3] = 1'b1; cyc();
    endtask

    task automatic test_repeated_start();
        sda[1] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, mst_idx} !== {4'b0010, 2'd1}) begin
            n_err++;
            $display("FAIL rs_lock: got ismst=%b idx=%0d, want 0010/1", ismst, mst_idx);
        end
        scl[1] = 1'b0; cyc();
        sda[1] = 1'b1; cyc();
        scl[1] = 1'b1; cyc();
        sda[1] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, start, stop} !== {4'b0010, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rs_pulse: got ismst=%b st=%b sp=%b, want 0010/1/0", ismst, start, stop);
        end
        sda[0] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, start, collision} !== {4'b0010, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rs_other_start: got ismst=%b st=%b col=%b, want 0010/0/0",
                     ismst, start, collision);
        end
        sda[0] = 1'b1; cyc();
        n_cmp++;
        if ({ismst, stop} !== {4'b0010, 1'b0}) begin
            n_err++;
            $display("FAIL rs_other_stop: got ismst=%b sp=%b, want 0010/0", ismst, stop);
        end
        sda[1] = 1'b1; cyc();
        n_cmp++;
        if ({ismst, stop} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL rs_stop: got ismst=%b sp=%b, want 0000/1", ismst, stop);
        end
    endtask

    task automatic test_idle_timeout();
        // last=1 -> ch2 wins; bring ch2 lines high without a STOP
        sda[2] = 1'b0; cyc();
        scl[2] = 1'b0; cyc();
        sda[2] = 1'b1; cyc();
        scl[2] = 1'b1; cyc();
        n_cmp++;
        if (ismst !== 4'b0100) begin
            n_err++;
            $display("FAIL to_lock: got ismst=%b, want 0100", ismst);
        end
        f_ref = 1'b1;
        for (int t = 1; t <= 811; t++) begin
            scl[2] = (t == 300) ? 1'b0 : 1'b1;
            cyc();
            if (t == 510 || t == 810) begin
                n_cmp++;
                if ({ismst, idle_to} !== {4'b0100, 1'b0}) begin
                    n_err++;
                    $display("FAIL to_early_t%0d: got ismst=%b to=%b, want 0100/0", t, ismst, idle_to);
                end
            end
            if (t == 811) begin
                n_cmp++;
                if ({ismst, idle_to} !== {4'b0000, 1'b1}) begin
                    n_err++;
                    $display("FAIL to_fire: got ismst=%b to=%b, want 0000/1", ismst, idle_to);
                end
            end
        end
        f_ref = 1'b0; cyc();
        n_cmp++;
        if (idle_to !== 1'b0) begin
            n_err++;
            $display("FAIL to_pulse_len: got to=%b, want 0", idle_to);
        end
    endtask

    task automatic test_violation_holdoff();
        // last=2 -> ch1 wins (search 3,0,1)
        sda[1] = 1'b0; cyc();
        violation = 1'b1; cyc();
        violation = 1'b0;
        n_cmp++;
        if ({ismst, disconnect} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL viol: got ismst=%b disc=%b, want 0000/1", ismst, disconnect);
        end
        f_ref = 1'b1;
        for (int t = 0; t < 50; t++) cyc();
        n_cmp++;
        if (disconnect !== 1'b1) begin
            n_err++;
            $display("FAIL disc_held: got disc=%b, want 1", disconnect);
        end
        sda[1] = 1'b1; cyc();
        for (int k = 1; k <= 58; k++) begin
            sda[3] = (k == 20) ? 1'b0 : 1'b1;
            cyc();
            if (k == 20) begin
                n_cmp++;
                if ({ismst, start, disconnect} !== {4'b0000, 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL ho_start_ignored: got ismst=%b st=%b disc=%b, want 0000/0/1",
                             ismst, start, disconnect);
                end
            end
            if (k == 38 || k == 57) begin
                n_cmp++;
                if (disconnect !== 1'b1) begin
                    n_err++;
                    $display("FAIL ho_early_k%0d: got disc=%b, want 1", k, disconnect);
                end
            end
            if (k == 58) begin
                n_cmp++;
                if ({disconnect, ismst} !== {1'b0, 4'b0000}) begin
                    n_err++;
                    $display("FAIL ho_release: got disc=%b ismst=%b, want 0/0000", disconnect, ismst);
                end
            end
        end
        f_ref = 1'b0;
    endtask

    task automatic test_stuck();
        stuck[2] = 1'b1; cyc();
        n_cmp++;
        if (disconnect !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_disc: got disc=%b, want 1", disconnect);
        end
        sda[0] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, start} !== {4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL stuck_start_ignored: got ismst=%b st=%b, want 0000/0", ismst, start);
        end
        sda[0] = 1'b1; stuck = 4'h0; f_ref = 1'b1; cyc();
        for (int k = 1; k <= 38; k++) begin
            cyc();
            if (k == 37 || k == 38) begin
                n_cmp++;
                if (disconnect !== (k == 37)) begin
                    n_err++;
                    $display("FAIL stuck_ho_k%0d: got disc=%b, want %b", k, disconnect, k == 37);
                end
            end
        end
        f_ref = 1'b0;
    endtask

    task automatic test_reset_mid();
        // last=1 -> ch0 alone wins (search 2,3,0)
        sda[0] = 1'b0; cyc();
        scl[0] = 1'b0; cyc();
        sda[0] = 1'b1; cyc();
        n_cmp++;
        if (ismst !== 4'b0001) begin
            n_err++;
            $display("FAIL rm_lock: got ismst=%b, want 0001", ismst);
        end
        rst = 1'b1; f_ref = 1'b1; cyc();
        n_cmp++;
        if ({ismst, mst_idx, disconnect, start, stop, idle_to, collision} !== 11'd0) begin
            n_err++;
            $display("FAIL rm_reset: got ismst=%b idx=%0d disc=%b, want 0000/0/0",
                     ismst, mst_idx, disconnect);
        end
        scl = 4'hF; sda = 4'hF; f_ref = 1'b0; cyc();
        rst = 1'b0;
        sda[0] = 1'b0; sda[1] = 1'b0; cyc();
        n_cmp++;
        if ({ismst, mst_idx, collision} !== {4'b0001, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rm_priority: got ismst=%b idx=%0d col=%b, want 0001/0/1",
                     ismst, mst_idx, collision);
        end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_collision();
        test_repeated_start();
        test_idle_timeout();
        test_violation_holdoff();
        test_stuck();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
